// File: rtl/i2c_core.sv
`timescale 1ns/1ps
// I2C slave core: 7-bit address {I_myaddr,3'b100}, 15 general registers plus a
// read-only status register, register pointer shared between writes and reads.
module i2c_core (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_scl,
    input  logic       I_sda,
    output logic       O_sda,
    output logic       OE_sda,
    input  logic [3:0] I_myaddr
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_WDATA     = 4'd4;
    localparam logic [3:0] ST_WACK      = 4'd5;
    localparam logic [3:0] ST_RDATA     = 4'd6;
    localparam logic [3:0] ST_RACK      = 4'd7;
    localparam logic [3:0] ST_WAIT_STOP = 4'd8;

    localparam logic [7:0] STATUS_PTR   = 8'h0F;

    logic [1:0]       scl_sync_q;
    logic [1:0]       sda_sync_q;
    logic             scl_prev_q;
    logic             sda_prev_q;
    logic             scl_s;
    logic             sda_s;
    logic             scl_rise_s;
    logic             scl_fall_s;
    logic             start_s;
    logic             stop_s;
    logic             mid_byte_s;

    logic [3:0]       state_q,   state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q,   shift_d;
    logic             phase_q,   phase_d;
    logic             rw_q,      rw_d;
    logic [7:0]       ptr_q,     ptr_d;
    logic             eflag_q,   eflag_d;
    logic             oe_q,      oe_d;
    logic             osda_q,    osda_d;
    logic [14:0][7:0] regs_q;

    logic             we_s;
    logic             eflag_set_s;
    logic             eflag_clr_s;
    logic [7:0]       rx_byte_s;
    logic [7:0]       rd_val_s;
    logic             rd_oor_s;

    function automatic logic [7:0] read_value(input logic [7:0]       ptr,
                                              input logic [14:0][7:0] regs,
                                              input logic             eflag);
        logic [7:0] val;
        if (ptr < STATUS_PTR) begin
            val = regs[ptr[3:0]];
        end else if (ptr == STATUS_PTR) begin
            val = {7'd0, eflag};
        end else begin
            val = 8'h00;
        end
        return val;
    endfunction

    // Bus input synchronizers plus one delayed copy for edge detection
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], I_scl};
            sda_sync_q <= {sda_sync_q[0], I_sda};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign scl_s      = scl_sync_q[1];
    assign sda_s      = sda_sync_q[1];
    assign scl_rise_s = scl_s & ~scl_prev_q;
    assign scl_fall_s = ~scl_s & scl_prev_q;
    // START/STOP: SDA moving while SCL stays high across both samples
    assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign mid_byte_s = (state_q == ST_REG) || (state_q == ST_WDATA) ||
                        (state_q == ST_RDATA);

    assign rx_byte_s  = {shift_q[6:0], sda_s};
    assign rd_val_s   = read_value(ptr_q, regs_q, eflag_q);
    assign rd_oor_s   = (ptr_q > STATUS_PTR);

    // Protocol state machine and next-state for all control registers
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        phase_d     = phase_q;
        rw_d        = rw_q;
        ptr_d       = ptr_q;
        oe_d        = oe_q;
        osda_d      = osda_q;
        we_s        = 1'b0;
        eflag_set_s = 1'b0;
        eflag_clr_s = 1'b0;

        if (start_s || stop_s) begin
            state_d     = start_s ? ST_ADDR : ST_IDLE;
            bit_cnt_d   = 3'd0;
            phase_d     = 1'b0;
            oe_d        = 1'b0;
            osda_d      = 1'b1;
            eflag_set_s = mid_byte_s;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    oe_d   = 1'b0;
                    osda_d = 1'b1;
                end
                ST_ADDR: begin
                    if (scl_rise_s) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = rx_byte_s[0];
                            phase_d = 1'b0;
                            if (rx_byte_s[7:1] == {I_myaddr, 3'b100}) begin
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end else begin
                            state_d = ST_ADDR;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s && !phase_q) begin
                        oe_d    = 1'b1;
                        osda_d  = 1'b0;
                        phase_d = 1'b1;
                    end else if (scl_fall_s) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            state_d     = ST_RDATA;
                            shift_d     = rd_val_s;
                            oe_d        = 1'b1;
                            osda_d      = rd_val_s[7];
                            eflag_set_s = rd_oor_s;
                        end else begin
                            state_d = ST_REG;
                            oe_d    = 1'b0;
                            osda_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_ADDR_ACK;
                    end
                end
                ST_REG, ST_WDATA: begin
                    if (scl_rise_s) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7 && state_q == ST_REG) begin
                            ptr_d   = rx_byte_s;
                            state_d = ST_WDATA;
                        end else if (bit_cnt_q == 3'd7) begin
                            phase_d = 1'b0;
                            state_d = ST_WACK;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_WACK: begin
                    // Out-of-range pointer: no write, SDA left released, flag raised
                    if (scl_fall_s && !phase_q) begin
                        phase_d = 1'b1;
                        if (ptr_q < STATUS_PTR) begin
                            we_s   = 1'b1;
                            oe_d   = 1'b1;
                            osda_d = 1'b0;
                        end else begin
                            eflag_set_s = 1'b1;
                        end
                    end else if (scl_fall_s) begin
                        phase_d = 1'b0;
                        oe_d    = 1'b0;
                        osda_d  = 1'b1;
                        state_d = ST_WAIT_STOP;
                    end else begin
                        state_d = ST_WACK;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall_s && bit_cnt_q == 3'd7) begin
                        bit_cnt_d   = 3'd0;
                        phase_d     = 1'b0;
                        oe_d        = 1'b0;
                        osda_d      = 1'b1;
                        state_d     = ST_RACK;
                        eflag_clr_s = (ptr_q == STATUS_PTR);
                    end else if (scl_fall_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        osda_d    = shift_q[6];
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
                ST_RACK: begin
                    // Master ACK reloads the same register; NACK ends the read
                    if (scl_rise_s && !phase_q) begin
                        if (sda_s) begin
                            state_d = ST_WAIT_STOP;
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else if (scl_fall_s && phase_q) begin
                        phase_d     = 1'b0;
                        bit_cnt_d   = 3'd0;
                        state_d     = ST_RDATA;
                        shift_d     = rd_val_s;
                        oe_d        = 1'b1;
                        osda_d      = rd_val_s[7];
                        eflag_set_s = rd_oor_s;
                    end else begin
                        state_d = ST_RACK;
                    end
                end
                ST_WAIT_STOP: begin
                    oe_d   = 1'b0;
                    osda_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    osda_d  = 1'b1;
                end
            endcase
        end
    end

    // Error flag: a set request wins over a clear in the same cycle
    always_comb begin
        if (eflag_set_s) begin
            eflag_d = 1'b1;
        end else if (eflag_clr_s) begin
            eflag_d = 1'b0;
        end else begin
            eflag_d = eflag_q;
        end
    end

    // Control and output registers
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            phase_q   <= 1'b0;
            rw_q      <= 1'b0;
            ptr_q     <= 8'h00;
            eflag_q   <= 1'b0;
            oe_q      <= 1'b0;
            osda_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            phase_q   <= phase_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            eflag_q   <= eflag_d;
            oe_q      <= oe_d;
            osda_q    <= osda_d;
        end
    end

    // General register file, written with the received data byte at ACK time
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            regs_q <= '0;
        end else if (we_s) begin
            regs_q[ptr_q[3:0]] <= shift_q;
        end
    end

    assign O_sda  = osda_q;
    assign OE_sda = oe_q;

endmodule

// File: tb/tb_i2c_core.sv
`timescale 1ns/1ps
// Bench acting as I2C master; a monitor checks every data-bit slot of SDA
// against expectations queued from a transaction-level register model.
module tb_i2c_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic [3:0] myaddr_v;
    logic       o_sda;
    logic       oe_sda;
    logic       bus_sda;

    i2c_core dut (
        .I_clk    (clk),
        .I_rst    (rst),
        .I_scl    (scl_m),
        .I_sda    (bus_sda),
        .O_sda    (o_sda),
        .OE_sda   (oe_sda),
        .I_myaddr (myaddr_v)
    );

    always #5 clk = ~clk;

    // Wired-AND bus: whoever pulls low wins
    assign bus_sda = sda_m & (oe_sda ? o_sda : 1'b1);

    typedef struct {
        logic  oe;
        logic  o;
        string nm;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         errors   = 0;
    logic       data_clk = 1'b0;
    int         oe_cnt   = 0;

    logic [7:0] m_regs[15];
    logic [7:0] m_ptr;
    logic       m_ef;

    always @(posedge clk) begin
        if (oe_sda) oe_cnt <= oe_cnt + 1;
    end

    // Monitor: one expectation consumed per data-bit SCL high phase
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge scl_m);
            #40;
            if (data_clk) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit got oe=%0b o=%0b want no slot", oe_sda, o_sda);
                end else begin
                    e = exp_q.pop_front();
                    if (oe_sda !== e.oe || (e.oe && o_sda !== e.o)) begin
                        errors++;
                        $display("FAIL %s got oe=%0b o=%0b want oe=%0b o=%0b",
                                 e.nm, oe_sda, o_sda, e.oe, e.o);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic push_exp(input logic oe, input logic o, input string nm);
        exp_t e;
        e.oe = oe;
        e.o  = o;
        e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        #40;
        data_clk = 1'b1;
        scl_m    = 1'b1;
        #80;
        scl_m    = 1'b0;
        data_clk = 1'b0;
        #40;
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        #40;
        scl_m = 1'b1;
        #40;
        sda_m = 1'b0;
        #40;
        scl_m = 1'b0;
        #40;
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        #40;
        scl_m = 1'b1;
        #40;
        sda_m = 1'b1;
        #80;
    endtask

    task automatic mbyte(input logic [7:0] v, input string nm);
        for (int i = 7; i >= 0; i--) begin
            push_exp(1'b0, 1'b1, nm);
            send_bit(v[i]);
        end
    endtask

    task automatic ack_slot(input logic exp_ack, input string nm);
        push_exp(exp_ack, 1'b0, nm);
        send_bit(1'b1);
    endtask

    // Value the slave must return for the current pointer, with its flag side effect
    task automatic m_load(output logic [7:0] v);
        if (m_ptr < 8'd15) begin
            v = m_regs[m_ptr[3:0]];
        end else if (m_ptr == 8'd15) begin
            v = {7'd0, m_ef};
        end else begin
            v    = 8'h00;
            m_ef = 1'b1;
        end
    endtask

    task automatic do_write(input logic [6:0] a7, input logic [7:0] rg, input logic [7:0] dat);
        logic match;
        match = (a7 == {myaddr_v, 3'b100});
        start_c();
        mbyte({a7, 1'b0}, "w_addr");
        ack_slot(match, "w_addr_ack");
        mbyte(rg, "w_reg");
        mbyte(dat, "w_data");
        if (match) begin
            m_ptr = rg;
            if (rg < 8'd15) m_regs[rg[3:0]] = dat;
            else            m_ef = 1'b1;
            ack_slot(rg < 8'd15, "w_data_ack");
        end else begin
            ack_slot(1'b0, "w_data_ack");
        end
        stop_c();
    endtask

    task automatic do_read(input logic [6:0] a7, input int nbytes);
        logic       match;
        logic [7:0] v;
        match = (a7 == {myaddr_v, 3'b100});
        start_c();
        mbyte({a7, 1'b1}, "r_addr");
        ack_slot(match, "r_addr_ack");
        if (match) begin
            for (int k = 0; k < nbytes; k++) begin
                m_load(v);
                for (int i = 7; i >= 0; i--) begin
                    push_exp(1'b1, v[i], "r_data");
                    send_bit(1'b1);
                end
                if (m_ptr == 8'd15) m_ef = 1'b0;
                push_exp(1'b0, 1'b1, "r_master_ack");
                send_bit(k == nbytes - 1);
            end
        end else begin
            mbyte(8'hFF, "r_ignored");
            ack_slot(1'b0, "r_ignored_ack");
        end
        stop_c();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = 8'h00;
        m_ptr = 8'h00;
        m_ef  = 1'b0;
    endtask

    initial begin : stim
        int oe_before;
        rst      = 1'b1;
        scl_m    = 1'b1;
        sda_m    = 1'b1;
        myaddr_v = 4'd2;
        model_reset();
        #55;
        chk("reset_oe", oe_sda, 1'b0);
        chk("reset_o", o_sda, 1'b1);
        rst = 1'b0;
        #100;

        // Basic write then readback
        do_write(7'h14, 8'h00, 8'hF0);
        do_read(7'h14, 1);
        // Master ACK: same register sent again
        do_read(7'h14, 3);

        // Wrong address: bus never driven, nothing changes
        myaddr_v  = 4'd3;
        oe_before = oe_cnt;
        do_write(7'h14, 8'h01, 8'h55);
        chk("mismatch_oe_cycles", oe_cnt - oe_before, 0);
        myaddr_v = 4'd2;
        do_read(7'h14, 1);

        // Error flag set, read once as 1, then cleared
        do_write(7'h14, 8'h20, 8'h11);
        do_write(7'h14, 8'h0F, 8'h00);
        do_read(7'h14, 1);
        do_read(7'h14, 1);
        // Out-of-range read returns 0 and sets the flag
        do_write(7'h14, 8'h30, 8'h22);
        do_read(7'h14, 1);
        do_write(7'h14, 8'h0F, 8'h00);
        do_read(7'h14, 2);

        // Repeated START after two address bits restarts address reception
        do_write(7'h14, 8'h05, 8'h3C);
        start_c();
        push_exp(1'b0, 1'b1, "partial_addr");
        send_bit(1'b0);
        push_exp(1'b0, 1'b1, "partial_addr");
        send_bit(1'b0);
        do_read(7'h14, 1);

        for (int n = 0; n < 30; n++) begin
            int unsigned r;
            logic [6:0]  a7;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: do_write(7'h14, 8'($urandom_range(0, 14)), 8'($urandom));
                4, 5, 6:    do_read(7'h14, int'($urandom_range(1, 3)));
                7: begin
                    a7 = 7'($urandom_range(0, 127));
                    if (a7 == 7'h14) a7 = 7'h15;
                    if ($urandom_range(0, 1) == 0) do_write(a7, 8'($urandom), 8'($urandom));
                    else                            do_read(a7, 1);
                end
                8: do_write(7'h14, 8'($urandom_range(15, 255)), 8'($urandom));
                default: begin
                    myaddr_v = 4'($urandom_range(0, 15));
                    do_write(7'h14, 8'($urandom_range(0, 14)), 8'($urandom));
                    myaddr_v = 4'd2;
                end
            endcase
        end

        // Reset in the middle of a read byte
        do_write(7'h14, 8'h00, 8'hA5);
        start_c();
        mbyte({7'h14, 1'b1}, "rr_addr");
        ack_slot(1'b1, "rr_addr_ack");
        for (int i = 7; i >= 5; i--) begin
            push_exp(1'b1, m_regs[0][i], "rr_data");
            send_bit(1'b1);
        end
        chk("pre_reset_driving", oe_sda, 1'b1);
        rst = 1'b1;
        #1;
        chk("midreset_oe", oe_sda, 1'b0);
        chk("midreset_o", o_sda, 1'b1);
        exp_q.delete();
        model_reset();
        sda_m = 1'b1;
        #40;
        scl_m = 1'b1;
        #100;
        rst = 1'b0;
        #100;
        do_read(7'h14, 1);
        chk("post_read_oe", oe_sda, 1'b0);

        #500;
        chk("leftover_expectations", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
